// File: rtl/cmac_pkg.sv
// Shared types and width/saturation helpers for the complex dot-product MAC.
package cmac_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic conj;
  } beat_tag_t;

  typedef enum logic [1:0] {
    PH_ACCUM,
    PH_FIRST,
    PH_LAST,
    PH_SINGLE
  } phase_e;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned len);
    return 2 * data_w + 1 + $clog2(len);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // Clip a sign-extended accumulator value into an out_w-bit signed range.
  function automatic logic signed [63:0] saturate(input  logic signed [63:0] value,
                                                  input  int unsigned        out_w,
                                                  output logic               clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    clipped = (value > hi) || (value < lo);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/cmplx_mult_pipe.sv
// Two-stage complex multiplier: partial products, then re/im combine with optional conj(b).
module cmplx_mult_pipe
  import cmac_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  beat_tag_t                in_tag,
  input  logic signed [DATA_W-1:0] a_real,
  input  logic signed [DATA_W-1:0] a_imag,
  input  logic signed [DATA_W-1:0] b_real,
  input  logic signed [DATA_W-1:0] b_imag,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic signed [2*DATA_W:0] out_re,
  output logic signed [2*DATA_W:0] out_im
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + 1;

  beat_tag_t                s1_tag;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  x_rr, x_ii, x_ri, x_ir, re_c, im_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
    end else if (en) begin
      s1_tag <= in_tag;
      p_rr   <= PROD_W'(a_real) * PROD_W'(b_real);
      p_ii   <= PROD_W'(a_imag) * PROD_W'(b_imag);
      p_ri   <= PROD_W'(a_real) * PROD_W'(b_imag);
      p_ir   <= PROD_W'(a_imag) * PROD_W'(b_real);
    end
  end

  always_comb begin
    x_rr = SUM_W'(p_rr);
    x_ii = SUM_W'(p_ii);
    x_ri = SUM_W'(p_ri);
    x_ir = SUM_W'(p_ir);
    if (s1_tag.conj) begin
      re_c = x_rr + x_ii;
      im_c = x_ir - x_ri;
    end else begin
      re_c = x_rr - x_ii;
      im_c = x_ri + x_ir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (en) begin
      out_valid <= s1_tag.valid;
      out_first <= s1_tag.first;
      out_last  <= s1_tag.last;
      out_re    <= re_c;
      out_im    <= im_c;
    end
  end

endmodule

// File: rtl/cmplx_dot_mac.sv
// Streaming complex dot-product MAC: accumulates LEN products a*b (or a*conj(b)) per result.
// Define CMAC_SATURATE_EN to clip results to OUT_W and flag out_ovf; otherwise results wrap.
module cmplx_dot_mac
  import cmac_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN    = 4,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_real,
  input  logic [DATA_W-1:0] a_imag,
  input  logic [DATA_W-1:0] b_real,
  input  logic [DATA_W-1:0] b_imag,
  input  logic              conj_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result_real,
  output logic [OUT_W-1:0]  result_imag,
  output logic              out_ovf
);

  localparam int unsigned ACC_W = acc_width(DATA_W, LEN);
  localparam int unsigned CNT_W = cnt_width(LEN);
  localparam int unsigned SUM_W = 2 * DATA_W + 1;

  logic                    adv;
  beat_tag_t               in_tag;
  logic [CNT_W-1:0]        cnt;
  logic                    conj_hold;
  logic                    s2_valid, s2_first, s2_last;
  logic signed [SUM_W-1:0] s2_re, s2_im;
  logic signed [ACC_W-1:0] acc_re, acc_im, nxt_re, nxt_im;
  logic [OUT_W-1:0]        conv_re, conv_im;
  logic                    conv_ovf;
  phase_e                  phase;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Beat position and conj mode are fixed at the input so each beat carries its own tags.
  always_comb begin
    in_tag       = '0;
    in_tag.valid = in_valid;
    in_tag.first = (cnt == '0);
    in_tag.last  = (cnt == CNT_W'(LEN - 1));
    in_tag.conj  = in_tag.first ? conj_b : conj_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      conj_hold <= 1'b0;
    end else if (in_valid && adv) begin
      cnt <= in_tag.last ? '0 : cnt + CNT_W'(1);
      if (in_tag.first) conj_hold <= conj_b;
    end
  end

  cmplx_mult_pipe #(.DATA_W(DATA_W)) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .in_tag   (in_tag),
    .a_real   (a_real),
    .a_imag   (a_imag),
    .b_real   (b_real),
    .b_imag   (b_imag),
    .out_valid(s2_valid),
    .out_first(s2_first),
    .out_last (s2_last),
    .out_re   (s2_re),
    .out_im   (s2_im)
  );

  always_comb begin
    unique case ({s2_first, s2_last})
      2'b11:   phase = PH_SINGLE;
      2'b10:   phase = PH_FIRST;
      2'b01:   phase = PH_LAST;
      default: phase = PH_ACCUM;
    endcase
    nxt_re = acc_re;
    nxt_im = acc_im;
    if (s2_valid) begin
      if (phase == PH_FIRST || phase == PH_SINGLE) begin
        nxt_re = ACC_W'(s2_re);
        nxt_im = ACC_W'(s2_im);
      end else begin
        nxt_re = acc_re + ACC_W'(s2_re);
        nxt_im = acc_im + ACC_W'(s2_im);
      end
    end
  end

`ifdef CMAC_SATURATE_EN
  logic               clip_re, clip_im;
  logic signed [63:0] sat_re, sat_im;

  always_comb begin
    sat_re   = saturate(64'(nxt_re), OUT_W, clip_re);
    sat_im   = saturate(64'(nxt_im), OUT_W, clip_im);
    conv_re  = OUT_W'(sat_re);
    conv_im  = OUT_W'(sat_im);
    conv_ovf = clip_re || clip_im;
  end
`else
  always_comb begin
    conv_re  = OUT_W'(nxt_re);
    conv_im  = OUT_W'(nxt_im);
    conv_ovf = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re      <= '0;
      acc_im      <= '0;
      out_valid   <= 1'b0;
      result_real <= '0;
      result_imag <= '0;
      out_ovf     <= 1'b0;
    end else if (adv) begin
      acc_re <= nxt_re;
      acc_im <= nxt_im;
      if (s2_valid && (phase == PH_LAST || phase == PH_SINGLE)) begin
        out_valid   <= 1'b1;
        result_real <= conv_re;
        result_imag <= conv_im;
        out_ovf     <= conv_ovf;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmplx_dot_mac.sv
// Self-checking bench for cmplx_dot_mac: constant vectors, stall/reset sequences, random vs. model.
module tb_cmplx_dot_mac;

  localparam int DATA_W = 8;
  localparam int LEN    = 4;
  localparam int OUT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
  logic                     conj_b = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [OUT_W-1:0]  result_real, result_imag;
  logic                     out_ovf;

  always #5 clk = ~clk;

  cmplx_dot_mac #(.DATA_W(DATA_W), .LEN(LEN), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_real     (a_real),
    .a_imag     (a_imag),
    .b_real     (b_real),
    .b_imag     (b_imag),
    .conj_b     (conj_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_real(result_real),
    .result_imag(result_imag),
    .out_ovf    (out_ovf)
  );

  typedef struct { int re; int im; int ovf; } res_t;
  typedef struct { int ar[LEN]; int ai[LEN]; int br[LEN]; int bi[LEN]; bit cj[LEN]; } vec_t;
  typedef struct { int ar; int ai; int br; int bi; bit cj; int er; int ei; int eo; } tv_t;

  res_t   got_q[$];
  res_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t t;
    if (rst_n && out_valid && out_ready) begin
      t.re  = int'(result_real);
      t.im  = int'(result_imag);
      t.ovf = int'(out_ovf);
      got_q.push_back(t);
    end
  end

  // Reference: exact complex dot product, conj mode taken from the first beat, then OUT_W conversion.
  function automatic int to_out(input longint v, output int clipped);
    longint lim, m;
    lim = longint'(1) << (OUT_W - 1);
    clipped = 0;
`ifdef CMAC_SATURATE_EN
    if (v > lim - 1) begin clipped = 1; return int'(lim - 1); end
    if (v < -lim) begin clipped = 1; return int'(-lim); end
    return int'(v);
`else
    m = v & ((lim << 1) - 1);
    if (m >= lim) m = m - (lim << 1);
    return int'(m);
`endif
  endfunction

  function automatic res_t ref_dot(input vec_t v);
    longint re, im;
    int c1, c2;
    res_t r;
    re = 0;
    im = 0;
    for (int k = 0; k < LEN; k++) begin
      if (v.cj[0]) begin
        re += longint'(v.ar[k] * v.br[k] + v.ai[k] * v.bi[k]);
        im += longint'(v.ai[k] * v.br[k] - v.ar[k] * v.bi[k]);
      end else begin
        re += longint'(v.ar[k] * v.br[k] - v.ai[k] * v.bi[k]);
        im += longint'(v.ar[k] * v.bi[k] + v.ai[k] * v.br[k]);
      end
    end
    r.re  = to_out(re, c1);
    r.im  = to_out(im, c2);
    r.ovf = (c1 != 0 || c2 != 0) ? 1 : 0;
    return r;
  endfunction

  function automatic vec_t mk_vec(input tv_t t);
    vec_t v;
    for (int k = 0; k < LEN; k++) begin
      v.ar[k] = t.ar; v.ai[k] = t.ai; v.br[k] = t.br; v.bi[k] = t.bi;
      v.cj[k] = (k == 0) ? t.cj : !t.cj;
    end
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < LEN; k++) begin
      v.ar[k] = int'($urandom_range(0, 255)) - 128;
      v.ai[k] = int'($urandom_range(0, 255)) - 128;
      v.br[k] = int'($urandom_range(0, 255)) - 128;
      v.bi[k] = int'($urandom_range(0, 255)) - 128;
      v.cj[k] = bit'($urandom_range(0, 1));
    end
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp_res(input string name, input res_t act, input res_t exp);
    chk({name, "_re"}, act.re, exp.re);
    chk({name, "_im"}, act.im, exp.im);
    chk({name, "_ovf"}, act.ovf, exp.ovf);
  endtask

  task automatic send_beat(input int ar, input int ai, input int br, input int bi, input bit cj);
    int n;
    a_real = DATA_W'(ar); a_imag = DATA_W'(ai);
    b_real = DATA_W'(br); b_imag = DATA_W'(bi);
    conj_b = cj;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input int max_gap);
    for (int k = 0; k < LEN; k++) begin
      repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
        @(posedge clk); #1;
      end
      send_beat(v.ar[k], v.ai[k], v.br[k], v.bi[k], v.cj[k]);
    end
  endtask

  task automatic get_res(input string name, output res_t r);
    int n;
    n = 0;
    r.re = 0; r.im = 0; r.ovf = 0;
    while (got_q.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (got_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_result required=result", name);
    end else begin
      r = got_q.pop_front();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t    tbl[5];
    vec_t   v;
    res_t   r, e, held;
    longint c0;
    int     n;
    bit     done;

    tbl[0] = '{1, 2, 3, 4, 1'b0, -20, 40, 0};
    tbl[1] = '{1, 2, 3, 4, 1'b1, 44, 8, 0};
    tbl[3] = '{2, -1, 1, 1, 1'b0, 12, 4, 0};
`ifdef CMAC_SATURATE_EN
    tbl[2] = '{-128, 0, -128, 0, 1'b0, 32767, 0, 1};
    tbl[4] = '{-128, 0, 127, 0, 1'b0, -32768, 0, 1};
`else
    tbl[2] = '{-128, 0, -128, 0, 1'b0, 0, 0, 0};
    tbl[4] = '{-128, 0, 127, 0, 1'b0, 512, 0, 0};
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {result_real, result_imag}, 0);
    chk("rst_ovf", out_ovf, 0);
    @(posedge clk); #1;

    // Latency from last accepted beat to out_valid
    send_vec(mk_vec(tbl[0]), 0);
    c0 = cyc;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", cyc - c0, 2);
    get_res("lat", r);
    e.re = -20; e.im = 40; e.ovf = 0;
    cmp_res("lat", r, e);

    // Constant vectors; conj_b flips after the first beat and must be ignored
    for (int i = 0; i < 5; i++) begin
      send_vec(mk_vec(tbl[i]), 0);
      get_res($sformatf("tbl%0d", i), r);
      e.re = tbl[i].er; e.im = tbl[i].ei; e.ovf = tbl[i].eo;
      cmp_res($sformatf("tbl%0d", i), r, e);
    end

    // Random in_valid gaps inside one vector
    send_vec(mk_vec(tbl[3]), 3);
    get_res("gaps", r);
    e.re = 12; e.im = 4; e.ovf = 0;
    cmp_res("gaps", r, e);

    // Three back-to-back vectors with a 5-cycle output stall on the first result
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_dot(rand_vec()));
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          v = rand_vec();
          exp_q.push_back(ref_dot(v));
          send_vec(v, 0);
        end
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", in_ready, 0);
        held.re = int'(result_real); held.im = int'(result_imag); held.ovf = int'(out_ovf);
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_hold", {out_valid, result_real, result_imag, out_ovf},
              {1'b1, 16'(held.re), 16'(held.im), 1'(held.ovf)});
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) begin
      get_res($sformatf("b2b%0d", i), r);
      cmp_res($sformatf("b2b%0d", i), r, exp_q.pop_front());
    end

    // Reset in the middle of a vector discards the partial sum
    send_beat(5, 5, 5, 5, 1'b0);
    send_beat(5, 5, 5, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < LEN; k++) send_beat(1, 0, 1, 0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_count", got_q.size(), 1);
    get_res("midrst", r);
    e.re = 4; e.im = 0; e.ovf = 0;
    cmp_res("midrst", r, e);

    // Random vectors, random gaps and random out_ready back-pressure
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v = rand_vec();
          exp_q.push_back(ref_dot(v));
          send_vec(v, 2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20; i++) begin
      get_res($sformatf("rnd%0d", i), r);
      cmp_res($sformatf("rnd%0d", i), r, exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
